spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_shifter.sv | 56 +++++
 rtl/spi_master.sv | 170 +++++++++++++++++
 tb/tb_spi_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and frame constants for the SPI initiator.
// Imported by spi_shifter and spi_master.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT_OUT,
    WAIT_RD,
    SHIFT_IN,
    GAP
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int RD_BITS    = 8;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: tx parallel-load/serial-out, rx serial-in register
// and a shared down-counter whose done flag paces every FSM phase.
module spi_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_val,
  input  logic                  shift_tx,
  input  logic                  shift_rx,
  input  logic                  sin,
  input  logic                  cnt_load,
  input  logic [CNT_W-1:0]      cnt_val,
  input  logic                  cnt_dec,
  output logic                  sout,
  output logic [RD_BITS-1:0]    rx_next,
  output logic                  done
);

  logic [FRAME_BITS-1:0] tx;
  logic [RD_BITS-1:0]    rx;
  logic [CNT_W-1:0]      cnt;

  assign sout    = tx[FRAME_BITS-1];
  assign rx_next = {rx[RD_BITS-2:0], sin};
  assign done    = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= '0;
      rx <= '0;
    end else if (clr) begin
      tx <= '0;
      rx <= '0;
    end else begin
      if (load)
        tx <= load_val;
      else if (shift_tx)
        tx <= {tx[FRAME_BITS-2:0], 1'b0};
      if (shift_rx)
        rx <= rx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt_load)
      cnt <= cnt_val;
    else if (cnt_dec && !done)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: 11-bit framed SPI initiator with RD_DATA read-back.
// Define SPI_MASTER_ABORT_EN to add the abort input.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
`endif
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  state_e state, state_d;

  logic ss_d, mosi_d, rsp_d, is_rd;
  logic sh_clr, sh_load, shift_tx, shift_rx;
  logic cnt_load, cnt_dec, done, sout;
  logic [CNT_W-1:0]   cnt_val;
  logic [RD_BITS-1:0] rx_next;

  spi_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sh_clr),
    .load     (sh_load),
    .load_val ({cmd_type, cmd_data}),
    .shift_tx (shift_tx),
    .shift_rx (shift_rx),
    .sin      (MISO),
    .cnt_load (cnt_load),
    .cnt_val  (cnt_val),
    .cnt_dec  (cnt_dec),
    .sout     (sout),
    .rx_next  (rx_next),
    .done     (done)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Outputs are computed one cycle ahead so SS_n/MOSI come from flops.
  always_comb begin
    state_d  = state;
    ss_d     = 1'b1;
    mosi_d   = 1'b0;
    rsp_d    = 1'b0;
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    shift_tx = 1'b0;
    shift_rx = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d = START;
          ss_d    = 1'b0;
          mosi_d  = cmd_type[1];
          sh_load = 1'b1;
        end
      end
      START: begin
        state_d  = SHIFT_OUT;
        ss_d     = 1'b0;
        mosi_d   = sout;
        shift_tx = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(FRAME_BITS - 1);
      end
      SHIFT_OUT: begin
        ss_d = 1'b0;
        if (done) begin
          cnt_load = 1'b1;
          if (is_rd) begin
            state_d = WAIT_RD;
            cnt_val = CNT_W'(RD_WAIT - 1);
          end else begin
            state_d = GAP;
            ss_d    = 1'b1;
            cnt_val = CNT_W'(IDLE_GAP - 1);
          end
        end else begin
          mosi_d   = sout;
          shift_tx = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      WAIT_RD: begin
        ss_d = 1'b0;
        if (done) begin
          state_d  = SHIFT_IN;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(RD_BITS - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SHIFT_IN: begin
        ss_d     = 1'b0;
        shift_rx = 1'b1;
        if (done) begin
          state_d  = GAP;
          ss_d     = 1'b1;
          rsp_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(IDLE_GAP - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (done)
          state_d = IDLE;
        else
          cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_MASTER_ABORT_EN
    if (abort && state != IDLE && state != GAP) begin
      state_d  = GAP;
      ss_d     = 1'b1;
      mosi_d   = 1'b0;
      rsp_d    = 1'b0;
      sh_clr   = 1'b1;
      sh_load  = 1'b0;
      shift_tx = 1'b0;
      shift_rx = 1'b0;
      cnt_load = 1'b1;
      cnt_dec  = 1'b0;
      cnt_val  = CNT_W'(IDLE_GAP - 1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      is_rd     <= 1'b0;
    end else begin
      state     <= state_d;
      SS_n      <= ss_d;
      MOSI      <= mosi_d;
      rsp_valid <= rsp_d;
      if (rsp_d)
        rsp_data <= rx_next;
      if (sh_load)
        is_rd <= (cmd_e'(cmd_type) == RD_DATA);
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames checked against a cycle-timing
// model of the SPI initiator, plus reset and abort scenarios.
module tb_spi_master;

  localparam int RD_WAIT  = 2;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] rsp_model;

  always #5 clk = ~clk;

  spi_master #(
    .RD_WAIT  (RD_WAIT),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_data  (cmd_data),
`ifdef SPI_MASTER_ABORT_EN
    .abort     (abort),
`endif
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      miso = 1'($urandom);
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_ss", ss_n, 1);
      chk("idle_busy", busy, 0);
      chk("idle_rspv", rsp_valid, 0);
      chk("idle_rspd", rsp_data, rsp_model);
    end
  endtask

  // One frame accepted in the next cycle T; k counts cycles after T.
  task automatic frame(input logic [1:0] t, input logic [7:0] d,
                       input logic [7:0] rb, input int glitch_at,
                       input int abort_at, input bit hold,
                       input logic [1:0] nt, input logic [7:0] nd);
    logic [9:0] f;
    bit rd, rsp_k;
    int body, last;
    logic ev_ss, ev_mosi;
    f = {t, d};
    rd = (t == 2'b11);
    body = 11 + (rd ? RD_WAIT + 8 : 0);
    if (abort_at > 0) body = abort_at;
    last = body + IDLE_GAP;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_type = t;
    cmd_data = d;
    miso = 1'($urandom);
    @(negedge clk);
    chk("ready_T", cmd_ready, 1);
    chk("ss_T", ss_n, 1);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      cmd_valid = (k == glitch_at) || (hold && k == last);
      if (hold && k == last) begin
        cmd_type = nt;
        cmd_data = nd;
      end else begin
        cmd_type = 2'($urandom);
        cmd_data = 8'($urandom);
      end
`ifdef SPI_MASTER_ABORT_EN
      abort = (k == abort_at);
`endif
      if (rd && k >= 12 + RD_WAIT && k <= 19 + RD_WAIT)
        miso = rb[19 + RD_WAIT - k];
      else
        miso = 1'($urandom);
      @(negedge clk);
      ev_ss = (k <= body) ? 1'b0 : 1'b1;
      if (k > body)      ev_mosi = 1'b0;
      else if (k == 1)   ev_mosi = t[1];
      else if (k <= 11)  ev_mosi = f[11 - k];
      else               ev_mosi = 1'b0;
      rsp_k = rd && abort_at == 0 && k == body + 1;
      if (rsp_k) rsp_model = rb;
      chk("ss", ss_n, ev_ss);
      chk("mosi", mosi, ev_mosi);
      chk("rspv", rsp_valid, rsp_k);
      chk("rspd", rsp_data, rsp_model);
      chk("ready", cmd_ready, 0);
      chk("busy", busy, 1);
    end
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = 2'b00;
    cmd_data = 8'h00;
    miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    rsp_model = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss", ss_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    frame(2'b00, 8'h3C, 8'h00, 0, 0, 1, 2'b01, 8'hA5);
    frame(2'b01, 8'hA5, 8'h00, 0, 0, 0, 2'b00, 8'h00);
    idle(1);
    frame(2'b10, 8'h3C, 8'h00, 0, 0, 0, 2'b00, 8'h00);
    frame(2'b11, 8'h00, 8'hA5, 0, 0, 0, 2'b00, 8'h00);
`ifdef SPI_MASTER_ABORT_EN
    frame(2'b11, 8'h00, 8'h5A, 0, 12, 0, 2'b00, 8'h00);
    idle(1);
`endif
    frame(2'b01, 8'h55, 8'h00, 5, 0, 0, 2'b00, 8'h00);
    idle(1);

    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_type = 2'b11;
    cmd_data = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    rsp_model = 8'h00;
    #1;
    chk("arst_ss", ss_n, 1);
    chk("arst_mosi", mosi, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    frame(2'b00, 8'hC3, 8'h00, 0, 0, 0, 2'b00, 8'h00);

    for (int i = 0; i < 25; i++) begin
      logic [1:0] t;
      logic [7:0] d, rb;
      int g, a;
      t = 2'($urandom);
      d = 8'($urandom);
      rb = 8'($urandom);
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 11)) : 0;
      a = 0;
`ifdef SPI_MASTER_ABORT_EN
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(1, 11));
`endif
      frame(t, d, rb, g, a, 0, 2'b00, 8'h00);
      idle(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
